// File: rtl/l2_prefetcher.sv
// Next-line prefetch engine beside the L2: fetches the block after each demand miss
// and offers it to the L2. Define L2_PF_FILTER_EN to drop repeat candidates of the last fetch.
module l2_prefetcher #(
  parameter int ADDR_W   = 16,
  parameter int BLOCK_W  = 128,
  parameter int OFFSET_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l2_miss_valid,
  input  logic [ADDR_W-1:0]  l2_miss_address,
  input  logic               dont_prefetch,
  output logic               prefetch_ready,
  output logic               prefetch_busy,
  output logic [ADDR_W-1:0]  prefetch_address,
  output logic [BLOCK_W-1:0] prefetch_wdata,
  output logic               pf_pmem_read,
  output logic [ADDR_W-1:0]  pf_pmem_address,
  input  logic               pf_pmem_resp,
  input  logic [BLOCK_W-1:0] pf_pmem_rdata,
  output logic [15:0]        prefetch_count
);

  // state | meaning
  // IDLE  | waiting for a candidate and a free pmem port
  // FETCH | own the pmem port, read outstanding at fetch_addr
  // HOLD  | block held and offered to the L2 until it accepts
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam int TAG_W = ADDR_W - OFFSET_W;

  state_t            state;
  logic              cand_valid;
  logic [ADDR_W-1:0] cand_addr;
  logic [ADDR_W-1:0] fetch_addr;
  logic [TAG_W:0]    next_tag;
  logic [ADDR_W-1:0] next_addr;
  logic              cap_ok;
  logic              miss_offset_unused;

  // The extra top bit of next_tag is the carry out of the last block in memory.
  assign next_tag  = {1'b0, l2_miss_address[ADDR_W-1:OFFSET_W]} + {{TAG_W{1'b0}}, 1'b1};
  assign next_addr = {next_tag[TAG_W-1:0], {OFFSET_W{1'b0}}};
  assign miss_offset_unused = ^l2_miss_address[OFFSET_W-1:0];

`ifdef L2_PF_FILTER_EN
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;
  assign cap_ok = l2_miss_valid && !next_tag[TAG_W] && !(last_valid && (last_addr == next_addr));
`else
  assign cap_ok = l2_miss_valid && !next_tag[TAG_W];
`endif

  assign pf_pmem_address = fetch_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      cand_valid       <= 1'b0;
      cand_addr        <= '0;
      fetch_addr       <= '0;
      prefetch_ready   <= 1'b0;
      prefetch_busy    <= 1'b0;
      pf_pmem_read     <= 1'b0;
      prefetch_address <= '0;
      prefetch_wdata   <= '0;
      prefetch_count   <= '0;
`ifdef L2_PF_FILTER_EN
      last_addr        <= '0;
      last_valid       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cand_valid && !dont_prefetch) begin
            state         <= FETCH;
            fetch_addr    <= cand_addr;
            cand_valid    <= 1'b0;
            pf_pmem_read  <= 1'b1;
            prefetch_busy <= 1'b1;
`ifdef L2_PF_FILTER_EN
            last_addr     <= cand_addr;
            last_valid    <= 1'b1;
`endif
          end
        end
        FETCH: begin
          if (pf_pmem_resp) begin
            state            <= HOLD;
            prefetch_wdata   <= pf_pmem_rdata;
            prefetch_address <= fetch_addr;
            pf_pmem_read     <= 1'b0;
            prefetch_busy    <= 1'b0;
            prefetch_ready   <= 1'b1;
          end
        end
        HOLD: begin
          if (!dont_prefetch) begin
            state          <= IDLE;
            prefetch_ready <= 1'b0;
            if (prefetch_count != 16'hFFFF)
              prefetch_count <= prefetch_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // Written after the FSM so a same-edge miss wins over the clear on FETCH entry.
      if (cap_ok) begin
        cand_addr  <= next_addr;
        cand_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_prefetcher.sv
// Bench for l2_prefetcher: directed scenarios plus a randomized run against a
// transaction-level reference model of the prefetch engine.
module tb_l2_prefetcher;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         l2_miss_valid = 1'b0;
  logic [15:0]  l2_miss_address = '0;
  logic         dont_prefetch = 1'b0;
  logic         pf_pmem_resp = 1'b0;
  logic [127:0] pf_pmem_rdata = '0;
  logic         prefetch_ready, prefetch_busy, pf_pmem_read;
  logic [15:0]  prefetch_address, pf_pmem_address, prefetch_count;
  logic [127:0] prefetch_wdata;

  int n_checks = 0;
  int n_fail = 0;

  // reference model
  logic         m_fetching, m_holding, m_cand_v, m_last_v;
  logic [15:0]  m_cand, m_faddr, m_paddr, m_last, m_count;
  logic [127:0] m_pdata;

  l2_prefetcher dut (
    .clk(clk), .reset(reset),
    .l2_miss_valid(l2_miss_valid), .l2_miss_address(l2_miss_address),
    .dont_prefetch(dont_prefetch),
    .prefetch_ready(prefetch_ready), .prefetch_busy(prefetch_busy),
    .prefetch_address(prefetch_address), .prefetch_wdata(prefetch_wdata),
    .pf_pmem_read(pf_pmem_read), .pf_pmem_address(pf_pmem_address),
    .pf_pmem_resp(pf_pmem_resp), .pf_pmem_rdata(pf_pmem_rdata),
    .prefetch_count(prefetch_count)
  );

  always #5 clk = ~clk;

  function automatic void model_update();
    int unsigned blk;
    logic [15:0] na;
    logic        old_lv;
    logic [15:0] old_last;
    if (!reset) begin
      m_fetching = 0; m_holding = 0; m_cand_v = 0; m_last_v = 0;
      m_cand = 0; m_faddr = 0; m_paddr = 0; m_last = 0; m_count = 0; m_pdata = 0;
      return;
    end
    old_lv = m_last_v;
    old_last = m_last;
    if (m_holding) begin
      if (!dont_prefetch) begin
        m_holding = 0;
        if (m_count != 16'hFFFF) m_count = m_count + 1;
      end
    end else if (m_fetching) begin
      if (pf_pmem_resp) begin
        m_fetching = 0; m_holding = 1; m_paddr = m_faddr; m_pdata = pf_pmem_rdata;
      end
    end else if (m_cand_v && !dont_prefetch) begin
      m_fetching = 1; m_faddr = m_cand; m_cand_v = 0;
      m_last = m_cand; m_last_v = 1;
    end
    if (l2_miss_valid) begin
      blk = (int'(l2_miss_address) / 16) + 1;
      if (blk < 4096) begin
        na = 16'(blk * 16);
`ifdef L2_PF_FILTER_EN
        if (!(old_lv && old_last == na)) begin m_cand = na; m_cand_v = 1; end
`else
        m_cand = na; m_cand_v = 1;
`endif
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    l2_miss_valid = 1'b0;
    pf_pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({prefetch_ready, prefetch_busy, pf_pmem_read} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000", {prefetch_ready, prefetch_busy, pf_pmem_read});
    end
    n_checks++;
    if ({prefetch_address, pf_pmem_address, prefetch_wdata, prefetch_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h want all 0", prefetch_address, pf_pmem_address,
               prefetch_wdata, prefetch_count);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [127:0] d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    l2_miss_valid = 1; l2_miss_address = 16'h1230;
    tick();
    n_checks++;
    if (pf_pmem_read !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_read: got %b want 0", pf_pmem_read);
    end
    tick();
    n_checks++;
    if ({pf_pmem_read, prefetch_busy, pf_pmem_address} !== {2'b11, 16'h1240}) begin
      n_fail++;
      $display("FAIL basic_fetch: got rd=%b busy=%b addr=%h want 1 1 1240", pf_pmem_read,
               prefetch_busy, pf_pmem_address);
    end
    tick(); tick();
    pf_pmem_resp = 1; pf_pmem_rdata = d;
    tick();
    n_checks++;
    if ({prefetch_ready, prefetch_busy, pf_pmem_read, prefetch_address, prefetch_wdata} !==
        {3'b100, 16'h1240, d}) begin
      n_fail++;
      $display("FAIL basic_hold: got rdy=%b busy=%b rd=%b addr=%h data=%h", prefetch_ready,
               prefetch_busy, pf_pmem_read, prefetch_address, prefetch_wdata);
    end
    tick();
    n_checks++;
    if ({prefetch_ready, prefetch_count} !== {1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL basic_accept: got rdy=%b count=%0d want 0 1", prefetch_ready, prefetch_count);
    end
  endtask

  task automatic test_wrap();
    int reads = 0;
    l2_miss_valid = 1; l2_miss_address = 16'hFFF8;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pf_pmem_read || prefetch_busy || prefetch_ready) reads++;
    end
    n_checks++;
    if (reads != 0) begin
      n_fail++; $display("FAIL wrap_no_fetch: got %0d active cycles want 0", reads);
    end
  endtask

  task automatic test_dont_prefetch();
    int bad = 0;
    logic [127:0] d = 128'h0F0F_1234_5678_9ABC_DEF0_1111_2222_3333;
    logic [15:0] c0;
    dont_prefetch = 1;
    l2_miss_valid = 1; l2_miss_address = 16'h5550;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pf_pmem_read) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL dp_blocks_fetch: got %0d read cycles want 0", bad);
    end
    dont_prefetch = 0;
    tick();
    n_checks++;
    if ({pf_pmem_read, pf_pmem_address} !== {1'b1, 16'h5560}) begin
      n_fail++;
      $display("FAIL dp_release: got rd=%b addr=%h want 1 5560", pf_pmem_read, pf_pmem_address);
    end
    dont_prefetch = 1;
    tick();
    n_checks++;
    if (pf_pmem_read !== 1'b1) begin
      n_fail++; $display("FAIL dp_no_abort: got rd=%b want 1", pf_pmem_read);
    end
    pf_pmem_resp = 1; pf_pmem_rdata = d;
    tick();
    c0 = m_count;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(prefetch_ready === 1'b1 && prefetch_address === 16'h5560 && prefetch_wdata === d &&
            prefetch_count === c0)) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL dp_hold_stable: got %0d unstable cycles want 0", bad);
    end
    dont_prefetch = 0;
    tick();
    n_checks++;
    if ({prefetch_ready, prefetch_count} !== {1'b0, c0 + 16'd1}) begin
      n_fail++;
      $display("FAIL dp_accept: got rdy=%b count=%0d want 0 %0d", prefetch_ready, prefetch_count,
               c0 + 16'd1);
    end
  endtask

  task automatic test_overwrite();
    int extra = 0;
    dont_prefetch = 1;
    l2_miss_valid = 1; l2_miss_address = 16'h2000;
    tick();
    l2_miss_valid = 1; l2_miss_address = 16'h3000;
    tick();
    dont_prefetch = 0;
    tick();
    n_checks++;
    if ({pf_pmem_read, pf_pmem_address} !== {1'b1, 16'h3010}) begin
      n_fail++;
      $display("FAIL overwrite_addr: got rd=%b addr=%h want 1 3010", pf_pmem_read, pf_pmem_address);
    end
    pf_pmem_resp = 1; pf_pmem_rdata = 128'h3;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pf_pmem_read) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++; $display("FAIL overwrite_single: got %0d extra read cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int bad = 0;
    l2_miss_valid = 1; l2_miss_address = 16'h6000;
    tick(); tick();
    n_checks++;
    if (pf_pmem_read !== 1'b1) begin
      n_fail++; $display("FAIL midreset_setup: got rd=%b want 1", pf_pmem_read);
    end
    reset = 0;
    tick();
    reset = 1;
    pf_pmem_resp = 1; pf_pmem_rdata = 128'hFFFF;
    tick();
    n_checks++;
    if ({prefetch_ready, prefetch_busy, pf_pmem_read, prefetch_address, pf_pmem_address,
         prefetch_wdata, prefetch_count} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy=%b busy=%b rd=%b pa=%h ma=%h d=%h c=%h",
               prefetch_ready, prefetch_busy, pf_pmem_read, prefetch_address, pf_pmem_address,
               prefetch_wdata, prefetch_count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (prefetch_ready) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL midreset_no_ready: got %0d ready cycles want 0", bad);
    end
  endtask

  task automatic test_filter();
    int fetches = 0;
`ifdef L2_PF_FILTER_EN
    int exp_fetches = 1;
`else
    int exp_fetches = 2;
`endif
    logic prev = 1'b0;
    for (int t = 0; t < 2; t++) begin
      l2_miss_valid = 1; l2_miss_address = 16'h4000;
      for (int i = 0; i < 8; i++) begin
        if (pf_pmem_read && pf_pmem_address == 16'h4010) pf_pmem_resp = 1;
        tick();
        if (pf_pmem_read && !prev) fetches++;
        prev = pf_pmem_read;
      end
    end
    n_checks++;
    if (fetches != exp_fetches) begin
      n_fail++; $display("FAIL filter_fetches: got %0d want %0d", fetches, exp_fetches);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    reset = 0; tick(); reset = 1;
    for (int i = 0; i < 3000; i++) begin
      l2_miss_valid = ($urandom_range(0, 3) == 0);
      l2_miss_address = ($urandom_range(0, 7) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                                    : 16'($urandom);
      dont_prefetch = ($urandom_range(0, 9) < 4);
      pf_pmem_resp = ($urandom_range(0, 2) == 0);
      pf_pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n_checks++;
      if ({prefetch_ready, prefetch_busy, pf_pmem_read, prefetch_address, pf_pmem_address,
           prefetch_wdata, prefetch_count} !==
          {m_holding, m_fetching, m_fetching, m_paddr, m_faddr, m_pdata, m_count}) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL random_cycle%0d: got rdy=%b busy=%b rd=%b pa=%h ma=%h c=%h want %b %b %b %h %h %h",
                   i, prefetch_ready, prefetch_busy, pf_pmem_read, prefetch_address,
                   pf_pmem_address, prefetch_count, m_holding, m_fetching, m_fetching, m_paddr,
                   m_faddr, m_count);
      end
    end
    dont_prefetch = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_dont_prefetch();
    test_overwrite();
    test_reset_mid_fetch();
    test_filter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_prefetcher.md
# l2_prefetcher

Next-line prefetch engine for the L2 cache: the producer side of the L2 prefetch interface (`prefetch_ready`, `prefetch_busy`, `prefetch_wdata`, `prefetch_address`, `dont_prefetch`).
- Watches L2 demand misses and computes the next sequential block address.
- Fetches that block from physical memory on its own port while the L2 is not using memory.
- Holds the block and its address until the L2 accepts it.
- Sits beside the L2 between the L2 and the physical-memory arbiter.

## Interface
Parameters:
- `ADDR_W`, 16, byte-address width.
- `BLOCK_W`, 128, block width in bits (`lc3b_block`).
- `OFFSET_W`, 4, block-offset bits; block = 2^OFFSET_W bytes.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; state is cleared on a rising edge where `reset`=0.
- `l2_miss_valid` in 1: one-cycle pulse when the L2 issues a demand pmem read.
- `l2_miss_address` in ADDR_W: address of that demand miss.
- `dont_prefetch` in 1: L2 busy/owns pmem; blocks new fetch starts and block handoff.
- `prefetch_ready` out 1: held block valid and offered to the L2.
- `prefetch_busy` out 1: prefetcher currently owns the pmem port.
- `prefetch_address` out ADDR_W: block-aligned address of the offered block.
- `prefetch_wdata` out BLOCK_W: offered block data.
- `pf_pmem_read` out 1: physical-memory read request.
- `pf_pmem_address` out ADDR_W: physical-memory read address, block-aligned.
- `pf_pmem_resp` in 1: physical-memory read complete, data valid.
- `pf_pmem_rdata` in BLOCK_W: physical-memory read data.
- `prefetch_count` out 16: saturating count of blocks accepted by the L2.

## Operation
- Candidate register (`cand_valid`, `cand_addr`):
  - On `l2_miss_valid`, `cand_addr` = {`l2_miss_address`[15:4] + 1, 4'b0} and `cand_valid`=1.
  - The addition is 12-bit. If it carries out (miss in block 0xFFF0), no candidate is created and any existing candidate is kept.
  - A new miss always overwrites a pending, not-yet-issued candidate. This applies in every state.
- FSM states IDLE, FETCH, HOLD:
  - IDLE -> FETCH when `cand_valid` && !`dont_prefetch`. On that edge: `fetch_addr` <= `cand_addr`, `cand_valid` <= 0.
    - If `l2_miss_valid` arrives on that same edge, the new candidate is written after the clear, so `cand_valid` stays 1 with the new address.
  - FETCH: `pf_pmem_read`=1, `pf_pmem_address`=`fetch_addr`, `prefetch_busy`=1.
    - FETCH -> HOLD on `pf_pmem_resp`. On that edge: `pf_pmem_rdata` is latched into `prefetch_wdata` and `fetch_addr` into `prefetch_address`.
    - `dont_prefetch` rising during FETCH does not abort the fetch.
  - HOLD: `prefetch_ready`=1.
    - Transfer occurs on any cycle with `prefetch_ready` && !`dont_prefetch`. On that edge: HOLD -> IDLE and `prefetch_count` += 1, saturating at 0xFFFF.
    - `prefetch_address` and `prefetch_wdata` are stable throughout HOLD.
- `pf_pmem_resp` in IDLE or HOLD is ignored. This covers a stale response after a reset taken mid-fetch.
- Reset (`reset`=0): state IDLE, `cand_valid`=0, `last_addr`=0, `last_valid`=0, `prefetch_count`=0. All outputs are 0, including `prefetch_wdata` and `prefetch_address`.

## Timing
- Candidate is visible the cycle after the miss pulse.
- FETCH is entered on the next edge if `dont_prefetch`=0. Best-case miss-to-`pf_pmem_read` latency: 2 cycles.
- Response to `prefetch_ready`: 1 cycle after the `pf_pmem_resp` edge.
- Minimum one cycle in HOLD. Back-to-back prefetches need at least one IDLE cycle between HOLD and the next FETCH.
- `prefetch_busy` equals (state==FETCH), registered. Never high in IDLE or HOLD.
- All outputs are registered or decoded from state registers only; there are no combinational paths from inputs to outputs.

## Configuration
- `L2_PF_FILTER_EN` defined: duplicate filter.
  - `last_addr`/`last_valid` record the address of the most recent FETCH entry.
  - A candidate equal to `last_addr` while `last_valid`=1 is discarded on capture.
- `L2_PF_FILTER_EN` undefined: no filter. Every qualifying miss produces a candidate; `last_*` registers are absent.

## Test plan
- Reset, then miss 0x1230 with `dont_prefetch`=0, resp after 3 cycles with data D -> `pf_pmem_address`=0x1240; `prefetch_ready` with address 0x1240 and wdata D; accepted next cycle; `prefetch_count`=1.
- Miss 0xFFF8 -> no `pf_pmem_read` ever; state stays IDLE.
- Candidate pending, `dont_prefetch` held high 10 cycles -> no `pf_pmem_read` until the cycle after it drops. With a block in HOLD, `prefetch_ready` is held for those 10 cycles with stable data and the count is unchanged.
- Misses 0x2000 then 0x3000 before FETCH is entered -> only 0x3010 is fetched.
- `reset`=0 mid-FETCH, then stray `pf_pmem_resp` -> all outputs 0; `prefetch_ready` stays 0.
- With `L2_PF_FILTER_EN`: two misses to 0x4000 in separate transactions -> a single fetch of 0x4010. Without the macro -> two fetches.
